// File: rtl/audio_st_i2s_tx.sv
// Avalon-ST sink that applies volume to stereo words and sends them out as FPGA-master I2S.
// Optional AUDIO_ST_I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module audio_st_i2s_tx #(
  parameter int BCLK_HALF = 8,
  parameter int SAMPLE_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        play,
  input  logic [6:0]  vol,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_dacdat,
  output logic        underrun
`ifdef AUDIO_ST_I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  logic [7:0]            div_cnt;
  logic [5:0]            bit_cnt;
  logic [5:0]            bit_nxt;
  logic [2*SAMPLE_W-1:0] hold_dat;
  logic                  hold_full;
  logic [2*SAMPLE_W-1:0] shift_dat;
  logic [2*SAMPLE_W-1:0] load_dat;
  logic                  div_wrap;
  logic                  fall_evt;
  logic                  frame_start;
  logic                  accept;
  logic [4:0]            pos;
  logic [4:0]            idx;
  logic [SAMPLE_W-1:0]   chan;
  logic                  data_bit;

  // Signed gain where 64 is unity; result is saturated back to 16 bits.
  function automatic logic [SAMPLE_W-1:0] scale(input logic [SAMPLE_W-1:0] s,
                                                input logic [6:0] g);
    logic signed [23:0] a;
    logic signed [23:0] b;
    logic signed [23:0] prod;
    logic signed [23:0] sh;
    a    = {{8{s[SAMPLE_W-1]}}, s};
    b    = {17'b0, g};
    prod = a * b;
    sh   = prod >>> 6;
    if (sh > 24'sd32767)       scale = 16'h7FFF;
    else if (sh < -24'sd32768) scale = 16'h8000;
    else                       scale = sh[15:0];
  endfunction

  assign div_wrap    = (div_cnt == 8'(BCLK_HALF - 1));
  assign fall_evt    = div_wrap & i2s_bclk;
  assign bit_nxt     = bit_cnt + 6'd1;
  assign frame_start = fall_evt & (bit_nxt == 6'd0);
  assign st_ready    = play & ~hold_full & ~reset;
  assign accept      = st_valid & st_ready;
  assign load_dat    = {scale(hold_dat[2*SAMPLE_W-1:SAMPLE_W], vol),
                        scale(hold_dat[SAMPLE_W-1:0], vol)};

  // One-BCLK-delayed I2S slot: position 0 is blank, 1..16 carry MSB first.
  always_comb begin
    pos      = bit_nxt[4:0];
    idx      = 5'd16 - pos;
    chan     = bit_nxt[5] ? shift_dat[SAMPLE_W-1:0] : shift_dat[2*SAMPLE_W-1:SAMPLE_W];
    data_bit = 1'b0;
    if (pos >= 5'd1 && pos <= 5'd16) data_bit = chan[idx[3:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_dacdat <= 1'b0;
      underrun   <= 1'b0;
      hold_dat   <= '0;
      hold_full  <= 1'b0;
      shift_dat  <= '0;
    end else begin
      underrun <= 1'b0;
      if (div_wrap) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (fall_evt) begin
        bit_cnt    <= bit_nxt;
        i2s_lrclk  <= bit_nxt[5];
        i2s_dacdat <= data_bit;
      end
      if (accept) begin
        hold_dat  <= st_data;
        hold_full <= 1'b1;
      end
      // Ready is low while hold is full, so accept and load never coincide.
      if (frame_start) begin
        if (play && hold_full) begin
          shift_dat <= load_dat;
          hold_full <= 1'b0;
        end else begin
          shift_dat <= '0;
          if (play) underrun <= 1'b1;
        end
      end
    end
  end

`ifdef AUDIO_ST_I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (frame_start && play && !hold_full && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_st_i2s_tx.sv
// Directed bench for audio_st_i2s_tx with BCLK_HALF=2 (frame = 256 clk cycles).
module tb_audio_st_i2s_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_data = '0;
  logic        st_ready;
  logic        play = 1'b0;
  logic [6:0]  vol = 7'd64;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_dacdat;
  logic        underrun;
`ifdef AUDIO_ST_I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int total = 0;
  int bad = 0;
  int ucount = 0;

  audio_st_i2s_tx #(.BCLK_HALF(2), .SAMPLE_W(16)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_data(st_data),
    .st_ready(st_ready), .play(play), .vol(vol), .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk), .i2s_dacdat(i2s_dacdat), .underrun(underrun)
`ifdef AUDIO_ST_I2S_TX_UNDERRUN_CNT_EN
    , .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (underrun) ucount++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_lr_edge(input logic lvl);
    logic prev;
    logic found;
    found = 1'b0;
    prev  = i2s_lrclk;
    for (int g = 0; g < 2000 && !found; g++) begin
      @(negedge clk);
      if (prev !== i2s_lrclk && i2s_lrclk === lvl) found = 1'b1;
      prev = i2s_lrclk;
    end
    if (!found) chk("lrclk_edge_timeout", 32'(found), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    int g;
    wait_lr_edge(1'b1);
    st_valid = 1'b1;
    st_data  = w;
    g = 0;
    while (!st_ready && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("send_ready_timeout", 32'(st_ready), 32'd1);
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  // Records dacdat at each BCLK rise of the next frame and unpacks both slots.
  task automatic capture(input int drop_at, output logic [15:0] l, output logic [15:0] r,
                         output logic rz);
    logic [63:0] fr;
    logic pb;
    int pos;
    int g;
    wait_lr_edge(1'b0);
    fr = '0; pb = 1'b0; pos = 0; g = 0;
    while (pos < 64 && g < 1000) begin
      @(negedge clk);
      g++;
      if (i2s_bclk && !pb) begin
        fr[pos] = i2s_dacdat;
        if (pos == drop_at) play = 1'b0;
        pos++;
      end
      pb = i2s_bclk;
    end
    chk("capture_len", 32'(pos), 32'd64);
    for (int p = 1; p <= 16; p++) begin
      l[16-p]   = fr[p];
      r[16-p]   = fr[32+p];
      fr[p]     = 1'b0;
      fr[32+p]  = 1'b0;
    end
    rz = (fr == 64'd0);
  endtask

  task automatic run_word(input string tag, input logic [6:0] v, input logic [31:0] w,
                          input logic [15:0] el, input logic [15:0] er);
    logic [15:0] l;
    logic [15:0] r;
    logic rz;
    vol = v;
    send_word(w);
    capture(-1, l, r, rz);
    chk({tag, "_left"}, 32'(l), 32'(el));
    chk({tag, "_right"}, 32'(r), 32'(er));
    chk({tag, "_pad_zero"}, 32'(rz), 32'd1);
  endtask

  initial begin
    logic [15:0] l;
    logic [15:0] r;
    logic rz;
    int base;
    int cnt;
    logic prev;
    logic found;
`ifdef AUDIO_ST_I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] cbase;
`endif

    repeat (3) @(negedge clk);
    chk("rst_bclk", 32'(i2s_bclk), 32'd0);
    chk("rst_lrclk", 32'(i2s_lrclk), 32'd0);
    chk("rst_dacdat", 32'(i2s_dacdat), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ready", 32'(st_ready), 32'd0);
    reset = 1'b0;

    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk("bclk_toggle", 32'(i2s_bclk), 32'((n / 2) % 2));
    end

    wait_lr_edge(1'b0);
    cnt = 0; found = 1'b0; prev = i2s_lrclk;
    while (!found && cnt < 600) begin
      @(negedge clk);
      cnt++;
      if (prev && !i2s_lrclk) found = 1'b1;
      prev = i2s_lrclk;
    end
    chk("lrclk_period", 32'(cnt), 32'd256);

    // Unity gain word: ready stays low while it waits in hold.
    vol  = 7'd64;
    play = 1'b1;
    send_word(32'h8001_7FFE);
    chk("ready_hold_full", 32'(st_ready), 32'd0);
    capture(-1, l, r, rz);
    chk("unity_left", 32'(l), 32'h8001);
    chk("unity_right", 32'(r), 32'h7FFE);
    chk("unity_pad_zero", 32'(rz), 32'd1);
    chk("ready_after_load", 32'(st_ready), 32'd1);

    run_word("sat", 7'd127, 32'h7FFF_8000, 16'h7FFF, 16'h8000);
    run_word("mute", 7'd0, 32'h1234_8765, 16'h0000, 16'h0000);
    run_word("half", 7'd32, 32'h0003_FFFD, 16'h0001, 16'hFFFE);
    run_word("gain96", 7'd96, 32'h0100_FF00, 16'h0180, 16'hFE80);

    // Three starved frames.
    st_valid = 1'b0;
    wait_lr_edge(1'b0);
    @(negedge clk);
    base = ucount;
`ifdef AUDIO_ST_I2S_TX_UNDERRUN_CNT_EN
    cbase = underrun_count;
`endif
    for (int k = 0; k < 3; k++) begin
      capture(-1, l, r, rz);
      chk("underrun_frame_zero", {15'd0, rz, l | r}, {15'd0, 1'b1, 16'h0000});
    end
    chk("underrun_pulses", 32'(ucount - base), 32'd3);
`ifdef AUDIO_ST_I2S_TX_UNDERRUN_CNT_EN
    chk("underrun_count", 32'(underrun_count - cbase), 32'd3);
`endif

    // Continuous stream with play dropped in the middle of a frame.
    vol      = 7'd64;
    st_data  = 32'h5A5A_0F0F;
    st_valid = 1'b1;
    wait_lr_edge(1'b1);
    capture(20, l, r, rz);
    chk("drop_frame_left", 32'(l), 32'h5A5A);
    chk("drop_frame_right", 32'(r), 32'h0F0F);
    chk("ready_play_low", 32'(st_ready), 32'd0);
    base = ucount;
    capture(-1, l, r, rz);
    chk("play0_zero", {15'd0, rz, l | r}, {15'd0, 1'b1, 16'h0000});
    chk("play0_no_underrun", 32'(ucount - base), 32'd0);
    play = 1'b1;
    capture(-1, l, r, rz);
    chk("hold_retained_left", 32'(l), 32'h5A5A);
    chk("hold_retained_right", 32'(r), 32'h0F0F);
    st_valid = 1'b0;

    // Reset while lrclk and bclk are both high.
    found = 1'b0;
    for (int g = 0; g < 2000 && !found; g++) begin
      @(negedge clk);
      if (i2s_lrclk && i2s_bclk) found = 1'b1;
    end
    chk("pre_reset_found", 32'(found), 32'd1);
    chk("pre_reset_ready", 32'(st_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_bclk", 32'(i2s_bclk), 32'd0);
    chk("mid_rst_lrclk", 32'(i2s_lrclk), 32'd0);
    chk("mid_rst_dacdat", 32'(i2s_dacdat), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_hold_empty", 32'(st_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
